// File: rtl/draw_pkg.sv
// Shared types and constants for the board display drawing path.
package draw_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    PEG   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] RED   = 3'b100;
  localparam logic [2:0] WHITE = 3'b111;

endpackage

// File: rtl/rect_scanner.sv
// Row-major 2-D counter: dx is the inner loop, dy the outer loop, wrapping to (0,0).
module rect_scanner (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] i_w,
  input  logic [7:0] i_h,
  input  logic       i_start,
  input  logic       i_advance,
  output logic [7:0] o_dx,
  output logic [7:0] o_dy,
  output logic       o_last,
  output logic       o_edge
);

  logic [7:0] r_dx;
  logic [7:0] r_dy;
  logic       w_dx_end;
  logic       w_dy_end;

  assign w_dx_end = (r_dx == i_w - 8'd1);
  assign w_dy_end = (r_dy == i_h - 8'd1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_dx <= 8'd0;
      r_dy <= 8'd0;
    end else if (i_start) begin
      r_dx <= 8'd0;
      r_dy <= 8'd0;
    end else if (i_advance) begin
      if (w_dx_end) begin
        r_dx <= 8'd0;
        r_dy <= w_dy_end ? 8'd0 : r_dy + 8'd1;
      end else begin
        r_dx <= r_dx + 8'd1;
      end
    end
  end

  assign o_dx   = r_dx;
  assign o_dy   = r_dy;
  assign o_last = w_dx_end && w_dy_end;
  assign o_edge = (r_dx == 8'd0) || w_dx_end || (r_dy == 8'd0) || w_dy_end;

endmodule

// File: rtl/peg_draw_controller.sv
// Arbitrates screen-clear and peg draw requests and scans rectangles into the VGA adapter.
// The scanner leads the outputs by one pixel so every output can be registered.
module peg_draw_controller #(
  parameter int         PEG_W        = 8,
  parameter int         PEG_H        = 7,
  parameter int         SCREEN_W     = draw_pkg::SCREEN_W,
  parameter int         SCREEN_H     = draw_pkg::SCREEN_H,
  parameter logic [2:0] CLEAR_COLOUR = draw_pkg::BLACK
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear_req,
  input  logic       peg_req,
  input  logic [7:0] peg_x,
  input  logic [7:0] peg_y,
  input  logic [2:0] peg_colour,
  input  logic       peg_full,
  output logic       clear_ack,
  output logic       peg_ack,
  output logic       busy,
  output logic       done,
  output logic [7:0] vga_x,
  output logic [7:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot
);
  import draw_pkg::*;

  localparam logic [7:0] LP_SW = 8'(SCREEN_W);
  localparam logic [7:0] LP_SH = 8'(SCREEN_H);
  localparam logic [7:0] LP_PW = 8'(PEG_W);
  localparam logic [7:0] LP_PH = 8'(PEG_H);

  state_t     r_state;
  logic       r_scan_end;
  logic [7:0] r_peg_x, r_peg_y;
  logic [2:0] r_peg_colour;
  logic       r_peg_full;
  logic       r_clear_ack, r_peg_ack, r_busy, r_done, r_vga_plot;
  logic [7:0] r_vga_x, r_vga_y;
  logic [2:0] r_vga_colour;

  state_t     w_nx_state;
  logic       w_nx_scan_end, w_start, w_advance, w_emit, w_latch;
  logic       w_nx_clear_ack, w_nx_peg_ack, w_nx_done;
  logic       w_is_clear, w_full, w_last, w_edge;
  logic [7:0] w_w, w_h, w_dx, w_dy, w_base_x, w_base_y;
  logic [8:0] w_sum_x, w_sum_y;
  logic [7:0] w_pix_x, w_pix_y;
  logic [2:0] w_pix_colour;
  logic       w_pix_plot;

  rect_scanner u_scan (
    .clock     (clock),
    .reset     (reset),
    .i_w       (w_w),
    .i_h       (w_h),
    .i_start   (w_start),
    .i_advance (w_advance),
    .o_dx      (w_dx),
    .o_dy      (w_dy),
    .o_last    (w_last),
    .o_edge    (w_edge)
  );

  // In IDLE the grant cycle emits pixel (0,0), so peg fields come straight from the inputs.
  always_comb begin
    w_is_clear = (r_state == CLEAR) || ((r_state == IDLE) && clear_req);
    w_w        = w_is_clear ? LP_SW : LP_PW;
    w_h        = w_is_clear ? LP_SH : LP_PH;
    w_base_x   = (r_state == IDLE) ? peg_x : r_peg_x;
    w_base_y   = (r_state == IDLE) ? peg_y : r_peg_y;
    w_full     = (r_state == IDLE) ? peg_full : r_peg_full;
    w_sum_x    = {1'b0, w_base_x} + {1'b0, w_dx};
    w_sum_y    = {1'b0, w_base_y} + {1'b0, w_dy};
    if (w_is_clear) begin
      w_pix_x      = w_dx;
      w_pix_y      = w_dy;
      w_pix_colour = CLEAR_COLOUR;
      w_pix_plot   = 1'b1;
    end else begin
      w_pix_x      = w_sum_x[7:0];
      w_pix_y      = w_sum_y[7:0];
      w_pix_colour = (r_state == IDLE) ? peg_colour : r_peg_colour;
      w_pix_plot   = (w_sum_x < {1'b0, LP_SW}) && (w_sum_y < {1'b0, LP_SH}) && (w_full || w_edge);
    end
  end

  always_comb begin
    w_nx_state     = r_state;
    w_nx_scan_end  = 1'b0;
    w_start        = 1'b0;
    w_advance      = 1'b0;
    w_emit         = 1'b0;
    w_latch        = 1'b0;
    w_nx_clear_ack = 1'b0;
    w_nx_peg_ack   = 1'b0;
    w_nx_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (clear_req) begin
          w_nx_state     = CLEAR;
          w_nx_clear_ack = 1'b1;
          w_emit         = 1'b1;
        end else if (peg_req) begin
          w_nx_state   = PEG;
          w_nx_peg_ack = 1'b1;
          w_latch      = 1'b1;
          w_emit       = 1'b1;
        end else begin
          w_start = 1'b1;
        end
      end
      CLEAR, PEG: begin
        if (r_scan_end) begin
          w_nx_state = DONE;
          w_nx_done  = 1'b1;
          w_start    = 1'b1;
        end else begin
          w_emit = 1'b1;
        end
      end
      DONE: begin
        w_nx_state = IDLE;
        w_start    = 1'b1;
      end
      default: w_nx_state = IDLE;
    endcase
    if (w_emit) begin
      w_advance     = 1'b1;
      w_nx_scan_end = w_last;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_scan_end   <= 1'b0;
      r_peg_x      <= 8'd0;
      r_peg_y      <= 8'd0;
      r_peg_colour <= 3'd0;
      r_peg_full   <= 1'b0;
      r_clear_ack  <= 1'b0;
      r_peg_ack    <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_vga_x      <= 8'd0;
      r_vga_y      <= 8'd0;
      r_vga_colour <= 3'd0;
      r_vga_plot   <= 1'b0;
    end else begin
      r_state     <= w_nx_state;
      r_scan_end  <= w_nx_scan_end;
      r_clear_ack <= w_nx_clear_ack;
      r_peg_ack   <= w_nx_peg_ack;
      r_busy      <= (w_nx_state != IDLE);
      r_done      <= w_nx_done;
      r_vga_plot  <= w_emit && w_pix_plot;
      if (w_latch) begin
        r_peg_x      <= peg_x;
        r_peg_y      <= peg_y;
        r_peg_colour <= peg_colour;
        r_peg_full   <= peg_full;
      end
      if (w_emit) begin
        r_vga_x      <= w_pix_x;
        r_vga_y      <= w_pix_y;
        r_vga_colour <= w_pix_colour;
      end
    end
  end

  assign clear_ack  = r_clear_ack;
  assign peg_ack    = r_peg_ack;
  assign busy       = r_busy;
  assign done       = r_done;
  assign vga_x      = r_vga_x;
  assign vga_y      = r_vga_y;
  assign vga_colour = r_vga_colour;
  assign vga_plot   = r_vga_plot;

endmodule

// File: tb/tb_peg_draw_controller.sv
// Directed bench for peg_draw_controller: peg fill/outline, clipping, clear priority, reset abort.
module tb_peg_draw_controller;

  logic       clock = 1'b0;
  logic       reset;
  logic       clear_req, peg_req;
  logic [7:0] peg_x, peg_y;
  logic [2:0] peg_colour;
  logic       peg_full;
  logic       clear_ack, peg_ack, busy, done;
  logic [7:0] vga_x, vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;

  peg_draw_controller dut (
    .clock      (clock),
    .reset      (reset),
    .clear_req  (clear_req),
    .peg_req    (peg_req),
    .peg_x      (peg_x),
    .peg_y      (peg_y),
    .peg_colour (peg_colour),
    .peg_full   (peg_full),
    .clear_ack  (clear_ack),
    .peg_ack    (peg_ack),
    .busy       (busy),
    .done       (done),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_pass = 0;
  logic [15:0] exp_q[$];
  bit   saw_interior;

  int nplot, busy_cyc, errs, done_gap;
  bit got_done, found;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Expected plot list for an 8x7 peg, row-major, with clipping and outline masking.
  task automatic build_peg(input int x, input int y, input bit full);
    exp_q.delete();
    for (int dy = 0; dy < 7; dy++)
      for (int dx = 0; dx < 8; dx++)
        if ((x + dx) < 160 && (y + dy) < 120 &&
            (full || dx == 0 || dx == 7 || dy == 0 || dy == 6))
          exp_q.push_back({8'(x + dx), 8'(y + dy)});
  endtask

  task automatic build_clear();
    exp_q.delete();
    for (int y = 0; y < 120; y++)
      for (int x = 0; x < 160; x++)
        exp_q.push_back({8'(x), 8'(y)});
  endtask

  task automatic wait_peg_ack(output bit ok, output bit saw_done);
    ok = 0;
    saw_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (done) saw_done = 1;
      if (peg_ack) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic req_peg(input logic [7:0] x, input logic [7:0] y, input logic [2:0] col,
                         input bit full, input bit hold);
    bit sd;
    peg_x = x; peg_y = y; peg_colour = col; peg_full = full;
    peg_req = 1'b1;
    wait_peg_ack(found, sd);
    chk("peg_ack", found, 1);
    if (!hold) peg_req = 1'b0;
  endtask

  // Starts on the ack cycle (first scan pixel) and runs until done or the limit.
  task automatic run_scan(input int limit, input bit chg, input logic [2:0] exp_col,
                          output int np, output int bc, output int er, output int gap,
                          output bit gd);
    int last_c = -1;
    np = 0; bc = 0; er = 0; gap = -1; gd = 0;
    saw_interior = 0;
    for (int c = 0; c < limit; c++) begin
      if (c > 0) @(negedge clock);
      if (chg && c == 1) peg_x = 8'd100;
      if (done) begin
        gd  = 1;
        gap = c - last_c;
        chk("done_plot_low", vga_plot, 0);
        break;
      end
      if (busy) bc++;
      if (vga_plot) begin
        if (np >= exp_q.size() || {vga_x, vga_y} !== exp_q[np] || vga_colour !== exp_col) er++;
        if (vga_x == 8'd38 && vga_y == 8'd39) saw_interior = 1;
        np++;
        last_c = c;
      end
    end
  endtask

  initial begin
    bit sd;
    reset = 1'b0;
    clear_req = 1'b0; peg_req = 1'b0;
    peg_x = 8'd0; peg_y = 8'd0; peg_colour = 3'd0; peg_full = 1'b0;
    #12;
    chk("rst_plot", vga_plot, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_acks", {clear_ack, peg_ack}, 0);
    chk("rst_xyc", {vga_x, vga_y, vga_colour}, 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // Full red peg
    req_peg(8'd28, 8'd30, 3'b100, 1'b1, 1'b0);
    chk("full_first_xy", {vga_x, vga_y}, {8'd28, 8'd30});
    build_peg(28, 30, 1);
    run_scan(100, 0, 3'b100, nplot, busy_cyc, errs, done_gap, got_done);
    chk("full_done", got_done, 1);
    chk("full_plots", nplot, 56);
    chk("full_busy_cycles", busy_cyc, 56);
    chk("full_seq", errs, 0);
    chk("full_done_gap", done_gap, 1);
    @(negedge clock);
    chk("full_idle_busy", busy, 0);

    // White outline
    req_peg(8'd37, 8'd38, 3'b111, 1'b0, 1'b0);
    build_peg(37, 38, 0);
    run_scan(100, 0, 3'b111, nplot, busy_cyc, errs, done_gap, got_done);
    chk("outline_done", got_done, 1);
    chk("outline_plots", nplot, 26);
    chk("outline_busy_cycles", busy_cyc, 56);
    chk("outline_seq", errs, 0);
    chk("outline_interior", saw_interior, 0);
    @(negedge clock);

    // Clipped at the bottom-right corner
    req_peg(8'd156, 8'd116, 3'b100, 1'b1, 1'b0);
    build_peg(156, 116, 1);
    run_scan(100, 0, 3'b100, nplot, busy_cyc, errs, done_gap, got_done);
    chk("clip_done", got_done, 1);
    chk("clip_plots", nplot, 16);
    chk("clip_busy_cycles", busy_cyc, 56);
    chk("clip_seq", errs, 0);
    @(negedge clock);

    // peg_x changes after the grant
    req_peg(8'd28, 8'd30, 3'b100, 1'b1, 1'b0);
    build_peg(28, 30, 1);
    run_scan(100, 1, 3'b100, nplot, busy_cyc, errs, done_gap, got_done);
    chk("chg_done", got_done, 1);
    chk("chg_plots", nplot, 56);
    chk("chg_seq", errs, 0);
    @(negedge clock);

    // Both requests together: clear wins, peg follows back-to-back
    peg_x = 8'd5; peg_y = 8'd6; peg_colour = 3'b111; peg_full = 1'b1;
    clear_req = 1'b1; peg_req = 1'b1;
    found = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (clear_ack || peg_ack) begin
        found = 1;
        break;
      end
    end
    chk("sim_clear_ack", clear_ack, 1);
    chk("sim_peg_ack_low", peg_ack, 0);
    clear_req = 1'b0;
    build_clear();
    run_scan(19300, 0, 3'b000, nplot, busy_cyc, errs, done_gap, got_done);
    chk("clear_done", got_done, 1);
    chk("clear_plots", nplot, 19200);
    chk("clear_busy_cycles", busy_cyc, 19200);
    chk("clear_seq", errs, 0);
    @(negedge clock);
    chk("b2b_idle_busy", busy, 0);
    chk("b2b_idle_ack", peg_ack, 0);
    @(negedge clock);
    chk("b2b_peg_ack", peg_ack, 1);
    peg_req = 1'b0;
    build_peg(5, 6, 1);
    run_scan(100, 0, 3'b111, nplot, busy_cyc, errs, done_gap, got_done);
    chk("b2b_peg_plots", nplot, 56);
    chk("b2b_peg_seq", errs, 0);
    @(negedge clock);

    // Reset at pixel 20 of a peg draw, request held through reset
    req_peg(8'd28, 8'd30, 3'b100, 1'b1, 1'b1);
    repeat (20) @(negedge clock);
    chk("pre_rst_xy", {vga_x, vga_y}, {8'd32, 8'd32});
    chk("pre_rst_plot", vga_plot, 1);
    reset = 1'b0;
    #1;
    chk("abort_plot", vga_plot, 0);
    chk("abort_busy", busy, 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    wait_peg_ack(found, sd);
    chk("regrant_ack", found, 1);
    chk("abort_no_done", sd, 0);
    chk("regrant_xy", {vga_x, vga_y}, {8'd28, 8'd30});
    peg_req = 1'b0;
    build_peg(28, 30, 1);
    run_scan(100, 0, 3'b100, nplot, busy_cyc, errs, done_gap, got_done);
    chk("regrant_done", got_done, 1);
    chk("regrant_plots", nplot, 56);
    chk("regrant_seq", errs, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
